// File: rtl/l2k_fetchq_if.sv
// l2k_fetchq_if: bundles the msched read port, redirect input and decode
// handshake of the Limn2600 prefetch queue.
//
// Handshake semantics (both directions):
//   msched side : read_enable/read_addr are held stable from assertion until the
//                 cycle read_rdy=1; read_rdy is a single-cycle pulse that
//                 qualifies read_value/read_addr_in.
//   decode side : an entry transfers on a rising edge where insn_valid=1 and
//                 insn_ready=1; insn/insn_pc are meaningful only while insn_valid=1.
interface l2k_fetchq_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   read_addr;
  logic [1:0]    read_size;
  logic          read_enable;
  logic          read_rdy;
  logic [31:0]   read_value;
  logic [31:0]   read_addr_in;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          insn_valid;
  logic [31:0]   insn;
  logic [31:0]   insn_pc;
  logic          insn_ready;
  logic [CW-1:0] count;

  // Fetch queue side.
  modport master (
    output read_addr, read_size, read_enable,
    input  read_rdy, read_value, read_addr_in,
    input  redirect, redirect_pc,
    output insn_valid, insn, insn_pc,
    input  insn_ready,
    output count
  );

  // msched / core side.
  modport slave (
    input  read_addr, read_size, read_enable,
    output read_rdy, read_value, read_addr_in,
    output redirect, redirect_pc,
    input  insn_valid, insn, insn_pc,
    output insn_ready,
    input  count
  );
endinterface

// File: rtl/l2k_fetchq.sv
// l2k_fetchq: instruction prefetch queue for the Limn2600 core.
// Issues sequential word fetches to msched (one outstanding at a time),
// buffers returned words in a DEPTH-entry FIFO and hands them to decode.
// A redirect flushes the FIFO and restarts at the new PC; a fetch already in
// flight at that moment is waited out and dropped (DISCARD state).
// Optional feature macro: L2K_FETCHQ_BYPASS_EN -- when the FIFO is empty, a
// returning word is presented to decode combinationally in its rdy cycle.
// state_o exposes the FSM state for debug.
module l2k_fetchq #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'hFFFE0000
) (
  input  logic         clk,
  input  logic         rst,
  l2k_fetchq_if.master fq,
  output logic [1:0]   state_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          en_q, en_d;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [31:0]   word_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];

  logic rdy_acc;
  logic hit;
  logic push;
  logic pop;
  logic bypass;
  logic bypass_take;

  // Classify this cycle's msched response and decode handshake.
  always_comb begin
    rdy_acc = fq.read_rdy & en_q;
    hit     = rdy_acc & (state_q == S_REQ) & ~fq.redirect &
              (fq.read_addr_in == fetch_pc_q);
`ifdef L2K_FETCHQ_BYPASS_EN
    bypass      = hit & (count_q == '0);
    bypass_take = bypass & fq.insn_ready;
`else
    bypass      = 1'b0;
    bypass_take = 1'b0;
`endif
    // A bypassed word consumed in its rdy cycle never enters the FIFO.
    push = hit & ~bypass_take;
    pop  = (count_q != '0) & fq.insn_ready & ~fq.redirect;
  end

  // FIFO occupancy, pointers and fetch PC.
  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fetch_pc_d = fetch_pc_q;
    if (fq.redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = fq.redirect_pc & ~32'h3;
    end else begin
      if (push)       wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)        rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
      // PC advances on every accepted word, bypassed or not; wraps mod 2^32.
      if (hit)        fetch_pc_d = fetch_pc_q + 32'd4;
    end
  end

  // Next FSM state; a slot is reserved for the outstanding request, so the
  // next request may only issue while count_d < DEPTH.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (count_d < DEPTH_C) state_d = S_REQ;
      end
      S_REQ: begin
        if (fq.redirect) begin
          state_d = (en_q && !fq.read_rdy) ? S_DISCARD : S_REQ;
        end else if (rdy_acc) begin
          state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        // The dropped word arrives; a redirect without rdy keeps waiting.
        if (fq.read_rdy) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
    en_d   = (state_d != S_IDLE);
    // DISCARD keeps the abandoned address on the bus until its rdy.
    addr_d = (state_d == S_DISCARD) ? addr_q : fetch_pc_d;
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= RESET_PC;
      en_q       <= 1'b0;
      addr_q     <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // FIFO storage; contents are don't-care while the entry is not valid.
  always_ff @(posedge clk) begin
    if (push) begin
      word_q[wr_ptr_q] <= fq.read_value;
      pc_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  assign fq.read_enable = en_q;
  assign fq.read_addr   = addr_q;
  assign fq.read_size   = 2'b10;
  assign fq.count       = count_q;
  assign state_o        = state_q;

`ifdef L2K_FETCHQ_BYPASS_EN
  assign fq.insn_valid = (count_q != '0) | bypass;
  assign fq.insn       = bypass ? fq.read_value   : word_q[rd_ptr_q];
  assign fq.insn_pc    = bypass ? fq.read_addr_in : pc_q[rd_ptr_q];
`else
  assign fq.insn_valid = (count_q != '0);
  assign fq.insn       = word_q[rd_ptr_q];
  assign fq.insn_pc    = pc_q[rd_ptr_q];
`endif
endmodule

// File: tb/tb_l2k_fetchq.sv
// tb_l2k_fetchq: drives l2k_fetchq with a behavioural msched responder and a
// decode consumer; returned words are scoreboarded against an expected queue.
module tb_l2k_fetchq;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'hFFFE0000;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  l2k_fetchq_if #(.DEPTH(DEPTH)) fq ();

  l2k_fetchq #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk     (clk),
    .rst     (rst),
    .fq      (fq),
    .state_o (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [63:0] exp_q[$];     // {pc, word} in expected delivery order
  logic [31:0] pop_log[$];   // insn_pc of delivered words since last flush
  int          n_vec = 0;
  int          n_err = 0;

  // stimulus controls
  logic        rst_req     = 1'b0;
  logic        redir_req   = 1'b0;
  logic [31:0] redir_pc_v  = '0;
  int          ready_mode  = 0;    // 0: pop_once only, 1: always, 2: random
  logic        pop_once    = 1'b0;
  int          lat         = 2;
  logic        lat_rand    = 1'b0;
  logic        corrupt_next = 1'b0;

  // msched model state
  logic        busy      = 1'b0;
  int          remaining = 0;
  logic [31:0] req_addr  = '0;
  logic        discard   = 1'b0;
  logic [31:0] exp_pc    = RESET_PC;
  int          n_fetch   = 0;
  logic        chk_refetch  = 1'b0;
  logic [31:0] refetch_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h5A5AC3C3;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic cycle();
    logic [63:0] e;
    logic [31:0] ain;
    @(negedge clk);
    check("count", 64'(fq.count), 64'(exp_q.size()));
    check("valid", fq.insn_valid, exp_q.size() != 0);
    check("state_legal", state_dbg == 2'd3, 0);
    if (busy) begin
      check("en_hold", fq.read_enable, 1);
      check("addr_hold", fq.read_addr, req_addr);
      check("read_size", fq.read_size, 2'b10);
    end

    rst            = rst_req;
    fq.redirect    = redir_req;
    fq.redirect_pc = redir_pc_v;
    case (ready_mode)
      0:       fq.insn_ready = pop_once;
      1:       fq.insn_ready = 1'b1;
      default: fq.insn_ready = 1'($urandom_range(0, 1));
    endcase
    pop_once    = 1'b0;
    fq.read_rdy = 1'b0;

    if (rst_req) begin
      exp_q.delete();
      pop_log.delete();
      exp_pc      = RESET_PC;
      busy        = 1'b0;
      discard     = 1'b0;
      chk_refetch = 1'b0;
    end else begin
      // decode consumer
      if (fq.insn_valid && fq.insn_ready && !redir_req) begin
        if (exp_q.size() == 0) begin
          check("pop_underflow", fq.insn_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("insn_pc", fq.insn_pc, e[63:32]);
          check("insn", fq.insn, e[31:0]);
          pop_log.push_back(fq.insn_pc);
        end
      end
      // msched responder
      if (busy) begin
        remaining--;
        if (remaining == 0) begin
          ain = corrupt_next ? (req_addr ^ 32'h100) : req_addr;
          fq.read_rdy     = 1'b1;
          fq.read_value   = mem_word(req_addr);
          fq.read_addr_in = ain;
          busy            = 1'b0;
          if (!redir_req && !discard && ain == exp_pc) begin
            exp_q.push_back({exp_pc, mem_word(exp_pc)});
            exp_pc += 32'd4;
          end
          if (corrupt_next && !redir_req && !discard) begin
            chk_refetch  = 1'b1;
            refetch_addr = req_addr;
          end
          corrupt_next = 1'b0;
          discard      = 1'b0;
        end
      end else if (fq.read_enable) begin
        busy      = 1'b1;
        remaining = lat_rand ? int'($urandom_range(1, 4)) : lat;
        req_addr  = fq.read_addr;
        n_fetch++;
        check("req_addr", fq.read_addr, exp_pc);
        if (chk_refetch) begin
          check("refetch", fq.read_addr, refetch_addr);
          chk_refetch = 1'b0;
        end
      end
      if (redir_req) begin
        if (busy) discard = 1'b1;
        exp_q.delete();
        pop_log.delete();
        exp_pc = redir_pc_v & ~32'h3;
      end
    end
    redir_req = 1'b0;
  endtask

  task automatic wait_pops(input string tag, input int n, input int budget);
    int i;
    for (i = 0; i < budget && pop_log.size() < n; i++) cycle();
    check(tag, 64'(pop_log.size() >= n), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst             = 1'b1;
    fq.read_rdy     = 1'b0;
    fq.read_value   = '0;
    fq.read_addr_in = '0;
    fq.redirect     = 1'b0;
    fq.redirect_pc  = '0;
    fq.insn_ready   = 1'b0;

    // reset state
    rst_req = 1'b1; ready_mode = 0;
    cycle(); cycle();
    check("rst_en", fq.read_enable, 0);
    check("rst_addr", fq.read_addr, RESET_PC);
    check("rst_count", 64'(fq.count), 0);
    check("rst_valid", fq.insn_valid, 0);
    rst_req = 1'b0;

    // sequential fetch from RESET_PC, rdy 2 cycles after enable
    ready_mode = 1; lat = 2;
    wait_pops("t1_pops", 3, 40);
    if (pop_log.size() >= 3) begin
      check("t1_pc0", pop_log[0], 32'hFFFE0000);
      check("t1_pc1", pop_log[1], 32'hFFFE0004);
      check("t1_pc2", pop_log[2], 32'hFFFE0008);
    end

    // fill with decode stalled: exactly DEPTH fetches, then one per pop
    rst_req = 1'b1; cycle(); rst_req = 1'b0;
    ready_mode = 0; n_fetch = 0;
    repeat (30) cycle();
    check("t2_fetches", 64'(n_fetch), 4);
    check("t2_en", fq.read_enable, 0);
    check("t2_count", 64'(fq.count), 4);
    pop_once = 1'b1; n_fetch = 0;
    repeat (20) cycle();
    check("t2_refill", 64'(n_fetch), 1);
    check("t2_count2", 64'(fq.count), 4);

    // redirect while a request is in flight
    ready_mode = 1; lat = 3;
    repeat (3) cycle();
    ready_mode = 0;
    for (int i = 0; i < 30 && !(busy && remaining == 3); i++) cycle();
    check("t3_inflight", 64'(busy && remaining == 3), 1);
    redir_req = 1'b1; redir_pc_v = 32'h00001002;
    cycle();
    cycle();
    check("t3_flush", 64'(fq.count), 0);
    ready_mode = 1;
    wait_pops("t3_pops", 1, 30);
    if (pop_log.size() >= 1) check("t3_pc", pop_log[0], 32'h00001000);

    // PC wrap across 2^32
    redir_req = 1'b1; redir_pc_v = 32'hFFFFFFF8; lat = 1;
    cycle();
    wait_pops("t4_pops", 3, 40);
    if (pop_log.size() >= 3) begin
      check("t4_pc0", pop_log[0], 32'hFFFFFFF8);
      check("t4_pc1", pop_log[1], 32'hFFFFFFFC);
      check("t4_pc2", pop_log[2], 32'h00000000);
    end

    // mismatched echo address: word dropped, same address refetched
    lat = 2; corrupt_next = 1'b1;
    repeat (20) cycle();
    check("t5_corrupt_sent", corrupt_next, 0);
    check("t5_refetch_seen", chk_refetch, 0);

    // reset mid-request with three entries held
    ready_mode = 0; lat = 2;
    rst_req = 1'b1; cycle(); rst_req = 1'b0;
    for (int i = 0; i < 40 && !(fq.count == 3 && busy); i++) cycle();
    check("t6_armed", 64'(fq.count == 3 && busy), 1);
    rst_req = 1'b1; cycle(); cycle(); rst_req = 1'b0;
    check("t6_en", fq.read_enable, 0);
    check("t6_count", 64'(fq.count), 0);
    check("t6_valid", fq.insn_valid, 0);
    ready_mode = 1;
    wait_pops("t6_pops", 1, 30);
    if (pop_log.size() >= 1) check("t6_pc", pop_log[0], RESET_PC);

    // random traffic: stalls, latencies, redirects, bad echoes
    ready_mode = 2; lat_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) begin
        redir_req  = 1'b1;
        redir_pc_v = ($urandom_range(0, 1) == 0) ? $urandom() : (32'hFFFFFFF0 | 32'($urandom_range(0, 15)));
      end
      if (!busy && $urandom_range(0, 14) == 0) corrupt_next = 1'b1;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
